// File: rtl/ram_port_ctrl.sv
// Load/store front end for one byte-write block RAM port (2-cycle read latency).
// Credit-based response buffer keeps responses in order and never stalls the pipeline.
module ram_port_ctrl #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned RSP_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  ram_en,
  output logic [3:0]            ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_din,
  output logic                  ram_regce,
  output logic                  ram_rst,
  input  logic [31:0]           ram_dout
);

  localparam int unsigned PW = $clog2(RSP_DEPTH);
  localparam int unsigned CW = PW + 2;
  localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_ILL  = 2'd3
  } size_e;

  typedef struct packed {
    logic       valid;
    logic       we;
    size_e      size;
    logic       uns;
    logic [1:0] off;
    logic       err;
  } sb_t;

  size_e          w_size;
  logic [1:0]     w_off;
  logic           w_err;
  logic           w_accept;
  logic [3:0]     w_lanes;
  logic [31:0]    w_din;
  logic [31:0]    w_fmt;
  logic [7:0]     w_byte;
  logic [15:0]    w_half;
  logic           w_push;
  logic           w_pop;
  logic [CW-1:0]  w_used;

  sb_t            r_s1;
  sb_t            r_s2;
  logic [31:0]    r_fifo_data [RSP_DEPTH];
  logic           r_fifo_err  [RSP_DEPTH];
  logic [PW-1:0]  r_wptr;
  logic [PW-1:0]  r_rptr;
  logic [PW:0]    r_count;

  assign w_size = size_e'(req_size);
  assign w_off  = req_addr[1:0];

  always_comb begin
    w_err   = 1'b0;
    w_lanes = 4'b1111;
    w_din   = req_wdata;
    case (w_size)
      SZ_BYTE: begin
        w_lanes = 4'b0001 << w_off;
        w_din   = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        w_err   = w_off[0];
        w_lanes = w_off[1] ? 4'b1100 : 4'b0011;
        w_din   = {2{req_wdata[15:0]}};
      end
      SZ_WORD: w_err = (w_off != 2'b00);
      default: w_err = 1'b1;
    endcase
  end

  // Credits count everything between accept and pop, so the FIFO can never overflow.
  assign w_used    = CW'(r_s1.valid) + CW'(r_s2.valid) + CW'(r_count);
  assign req_ready = !rst && (w_used < DEPTH_C);
  assign w_accept  = req_valid && req_ready;

  assign ram_en    = w_accept && !w_err;
  assign ram_we    = (ram_en && req_we) ? w_lanes : '0;
  assign ram_addr  = req_addr[ADDR_WIDTH+1:2];
  assign ram_din   = w_din;
  assign ram_regce = 1'b1;
  assign ram_rst   = rst;

  assign w_byte = ram_dout[{r_s2.off, 3'b000} +: 8];
  assign w_half = r_s2.off[1] ? ram_dout[31:16] : ram_dout[15:0];

  always_comb begin
    w_fmt = '0;
    if (!r_s2.we && !r_s2.err) begin
      case (r_s2.size)
        SZ_BYTE: w_fmt = {{24{!r_s2.uns && w_byte[7]}}, w_byte};
        SZ_HALF: w_fmt = {{16{!r_s2.uns && w_half[15]}}, w_half};
        default: w_fmt = ram_dout;
      endcase
    end
  end

  assign w_push    = r_s2.valid;
  assign w_pop     = rsp_valid && rsp_ready;
  assign rsp_valid = (r_count != '0);
  assign rsp_rdata = rsp_valid ? r_fifo_data[r_rptr] : '0;
  assign rsp_err   = rsp_valid && r_fifo_err[r_rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_s1 <= '{valid: w_accept, we: req_we, size: w_size, uns: req_unsigned,
                off: w_off, err: w_err};
      r_s2 <= r_s1;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wptr] <= w_fmt;
      r_fifo_err[r_wptr]  <= r_s2.err;
    end
  end

endmodule

// File: tb/tb_ram_port_ctrl.sv
// Bench for ram_port_ctrl: behavioural RAM, byte-level memory model and an
// in-order expected-response queue checked every cycle, plus directed literals.
module tb_ram_port_ctrl;

  localparam int unsigned AW    = 10;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [1:0]    req_size = 2'd0;
  logic          req_unsigned = 1'b0;
  logic [AW+1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          ram_en;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_din;
  logic          ram_regce;
  logic          ram_rst;
  logic [31:0]   ram_dout = '0;

  ram_port_ctrl #(.ADDR_WIDTH(AW), .RSP_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_regce(ram_regce), .ram_rst(ram_rst), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Read-first byte-write RAM with a 2-stage read path.
  logic [31:0] ram_mem [1024] = '{default: '0};
  logic [31:0] ram_q1 = '0;
  always @(posedge clk) begin
    if (ram_en) begin
      ram_q1 <= ram_mem[ram_addr];
      for (int j = 0; j < 4; j++)
        if (ram_we[j]) ram_mem[ram_addr][8*j +: 8] <= ram_din[8*j +: 8];
    end
    ram_dout <= ram_q1;
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;
  int unsigned stall_cnt = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned acc_cyc;
  } exp_t;

  exp_t        exp_q [$];
  logic [31:0] pop_hist [$];
  logic        err_hist [$];
  int unsigned lat_hist [$];
  int unsigned cyc_hist [$];
  logic [7:0]  mbytes [4096] = '{default: '0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: every sample point sits 2 time units after the falling edge.
  exp_t        m_e;
  int unsigned m_a, m_n;
  logic        m_err;
  logic [31:0] m_v, m_mask, m_din, m_lanes;
  initial begin
    forever begin
      @(negedge clk); #2;
      if (rst) begin
        exp_q.delete();
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_rsp_data", {rsp_rdata[30:0], rsp_err}, 32'd0);
        check("rst_ram_en_we", {27'd0, ram_en, ram_we}, 32'd0);
      end else begin
        check("req_ready_credit", {31'd0, req_ready},
              {31'd0, (exp_q.size() < DEPTH)});
        if (exp_q.size() == 0) begin
          check("rsp_spurious", {31'd0, rsp_valid}, 32'd0);
        end else begin
          if (cyc >= exp_q[0].acc_cyc + 3)
            check("rsp_valid_due", {31'd0, rsp_valid}, 32'd1);
          if (rsp_valid) begin
            check("rsp_rdata", rsp_rdata, exp_q[0].rdata);
            check("rsp_err", {31'd0, rsp_err}, {31'd0, exp_q[0].err});
            if (rsp_ready) begin
              m_e = exp_q.pop_front();
              pop_hist.push_back(rsp_rdata);
              err_hist.push_back(rsp_err);
              lat_hist.push_back(cyc - m_e.acc_cyc);
              cyc_hist.push_back(cyc);
            end
          end
        end
        if (req_valid && req_ready) begin
          m_a   = int'(req_addr);
          m_n   = (req_size == 2'd0) ? 1 : (req_size == 2'd1) ? 2 : 4;
          m_err = (req_size == 2'd3) || (m_a % m_n != 0);
          m_v   = '0;
          if (m_err) begin
            check("err_no_ram", {27'd0, ram_en, ram_we}, 32'd0);
          end else begin
            check("ram_addr", {22'd0, ram_addr}, m_a / 4);
            if (req_we) begin
              m_lanes = '0; m_mask = '0; m_din = '0;
              for (int i = 0; i < int'(m_n); i++) begin
                m_lanes[(m_a % 4) + i] = 1'b1;
                m_mask[8*((m_a % 4) + i) +: 8] = 8'hFF;
                m_din[8*((m_a % 4) + i) +: 8] = req_wdata[8*i +: 8];
                mbytes[m_a + i] = req_wdata[8*i +: 8];
              end
              check("store_en_we", {27'd0, ram_en, ram_we}, {27'd0, 1'b1, m_lanes[3:0]});
              check("store_din", ram_din & m_mask, m_din);
            end else begin
              check("load_en_we", {27'd0, ram_en, ram_we}, 32'h10);
              for (int i = 0; i < int'(m_n); i++) m_v[8*i +: 8] = mbytes[m_a + i];
              if (m_n < 4 && !req_unsigned && m_v[8*m_n-1])
                m_v = m_v | ~((32'd1 << (8*m_n)) - 32'd1);
            end
          end
          m_e.rdata   = m_v;
          m_e.err     = m_err;
          m_e.acc_cyc = cyc;
          exp_q.push_back(m_e);
        end else begin
          check("idle_ram", {27'd0, ram_en, ram_we}, 32'd0);
        end
      end
    end
  end

  task automatic send(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [11:0] addr, input logic [31:0] wd);
    int unsigned guard = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    #1;
    while (!req_ready && guard < 100) begin
      stall_cnt++;
      @(negedge clk); #1;
      guard++;
    end
    if (!req_ready) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  task automatic drain();
    int unsigned guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 32'd0);
    @(negedge clk);
  endtask

  task automatic clear_hist();
    pop_hist.delete(); err_hist.delete(); lat_hist.delete(); cyc_hist.delete();
  endtask

  int unsigned acc;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("ram_regce", {31'd0, ram_regce}, 32'd1);
    check("ram_rst", {31'd0, ram_rst}, 32'd1);
    #3 rst = 1'b0;
    @(negedge clk); #1;
    check("ready_after_reset", {31'd0, req_ready}, 32'd1);

    // Word store then load.
    clear_hist();
    send(1'b1, 2'd2, 1'b0, 12'h010, 32'hDEADBEEF);
    check("sw_we", {28'd0, ram_we}, 32'hF);
    check("sw_addr", {22'd0, ram_addr}, 32'd4);
    check("sw_din", ram_din, 32'hDEADBEEF);
    send(1'b0, 2'd2, 1'b0, 12'h010, 32'h0);
    idle(); drain();
    if (pop_hist.size() == 2) begin
      check("sw_rsp", pop_hist[0], 32'h0);
      check("lw_rsp", pop_hist[1], 32'hDEADBEEF);
      check("lw_lat", lat_hist[1], 32'd3);
    end else check("sw_lw_count", pop_hist.size(), 32'd2);

    // Byte lanes and extension.
    clear_hist();
    send(1'b1, 2'd0, 1'b0, 12'h013, 32'h0000005A);
    check("sb_we", {28'd0, ram_we}, 32'h8);
    check("sb_din", ram_din, 32'h5A5A5A5A);
    send(1'b0, 2'd0, 1'b0, 12'h013, 32'h0);
    send(1'b1, 2'd0, 1'b0, 12'h013, 32'h00000080);
    send(1'b0, 2'd0, 1'b0, 12'h013, 32'h0);
    send(1'b0, 2'd0, 1'b1, 12'h013, 32'h0);
    send(1'b1, 2'd1, 1'b0, 12'h022, 32'h1234CAFE);
    check("sh_we", {28'd0, ram_we}, 32'hC);
    check("sh_din", ram_din, 32'hCAFECAFE);
    send(1'b0, 2'd1, 1'b0, 12'h022, 32'h0);
    send(1'b0, 2'd1, 1'b1, 12'h020, 32'h0);
    idle(); drain();
    if (pop_hist.size() == 8) begin
      check("lb_5a", pop_hist[1], 32'h0000005A);
      check("lb_signed", pop_hist[3], 32'hFFFFFF80);
      check("lbu", pop_hist[4], 32'h00000080);
      check("lh_signed", pop_hist[6], 32'hFFFFCAFE);
      check("lhu_zero", pop_hist[7], 32'h00000000);
    end else check("byte_count", pop_hist.size(), 32'd8);

    // Alignment and illegal-size errors.
    clear_hist();
    send(1'b0, 2'd1, 1'b0, 12'h011, 32'h0);
    check("err_half_en", {31'd0, ram_en}, 32'd0);
    send(1'b1, 2'd2, 1'b0, 12'h012, 32'h11111111);
    check("err_word_en", {27'd0, ram_en, ram_we}, 32'd0);
    send(1'b1, 2'd3, 1'b0, 12'h010, 32'h22222222);
    check("err_size_en", {27'd0, ram_en, ram_we}, 32'd0);
    send(1'b0, 2'd2, 1'b0, 12'h010, 32'h0);
    idle(); drain();
    if (pop_hist.size() == 4) begin
      check("err_flags", {29'd0, err_hist[0], err_hist[1], err_hist[2]}, 32'd7);
      check("err_rdata", pop_hist[0] | pop_hist[1] | pop_hist[2], 32'd0);
      check("mem_unchanged", pop_hist[3], 32'h80ADBEEF);
    end else check("err_count", pop_hist.size(), 32'd4);

    // Back-to-back throughput.
    clear_hist();
    stall_cnt = 0;
    for (int i = 0; i < 16; i++) send(1'b1, 2'd2, 1'b0, 12'(12'h040 + 4*i), 32'h10000000 + i);
    for (int i = 0; i < 16; i++) send(1'b0, 2'd2, 1'b0, 12'(12'h040 + 4*i), 32'h0);
    idle(); drain();
    check("b2b_stalls", stall_cnt, 32'd0);
    if (pop_hist.size() == 32) begin
      check("b2b_store_rsp", pop_hist[0], 32'h0);
      check("b2b_first", pop_hist[16], 32'h10000000);
      check("b2b_last", pop_hist[31], 32'h1000000F);
      check("b2b_rate", cyc_hist[31] - cyc_hist[0], 32'd31);
    end else check("b2b_count", pop_hist.size(), 32'd32);

    // Backpressure: exactly DEPTH credits.
    clear_hist();
    @(negedge clk);
    rsp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
      req_addr = 12'h040; req_wdata = '0;
      #1;
      if (req_ready) acc++;
    end
    check("bp_accepts", acc, DEPTH);
    check("bp_ready_low", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    req_valid = 1'b0; rsp_ready = 1'b1;
    drain();
    if (pop_hist.size() == DEPTH) begin
      check("bp_drain0", pop_hist[0], 32'h10000000);
      check("bp_drain3", pop_hist[3], 32'h10000000);
    end else check("bp_count", pop_hist.size(), DEPTH);
    #1;
    check("bp_resume", {31'd0, req_ready}, 32'd1);

    // Reset with two in flight and two buffered.
    clear_hist();
    @(negedge clk);
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(1'b0, 2'd2, 1'b0, 12'h044, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("pre_rst_buffered", {31'd0, rsp_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_imm_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_imm_ready", {31'd0, req_ready}, 32'd0);
    check("rst_imm_data", rsp_rdata, 32'd0);
    repeat (2) @(negedge clk);
    #3 rst = 1'b0; rsp_ready = 1'b1;
    @(negedge clk); #1;
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);
    repeat (8) @(negedge clk);
    check("no_stale", pop_hist.size(), 32'd0);
    send(1'b0, 2'd2, 1'b0, 12'h048, 32'h0);
    idle(); drain();
    if (pop_hist.size() == 1) check("post_rst_load", pop_hist[0], 32'h10000002);
    else check("post_rst_count", pop_hist.size(), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
